// File: rtl/txsrc_mux_if.sv
// Bus between the transmit bit-source mux and its sources/sequencer.
// The slave side is the mux; the master side drives starts, selects and source data.
interface txsrc_mux_if #(
    parameter int NSRC = 4,
    parameter int SELW = 2,
    parameter int CNTW = 10
);
    logic            tx_start;
    logic            tx_abort;
    logic [SELW-1:0] src_sel;
    logic            bit_req;
    logic [NSRC-1:0] src_bit;
    logic [NSRC-1:0] src_done;
    logic [NSRC-1:0] src_bitreq;
    logic            tx_bit;
    logic            tx_datadone;
    logic            busy;
    logic            sel_err;
    logic            overrun;
    logic [CNTW-1:0] bit_count;

    modport slave (
        input  tx_start, tx_abort, src_sel, bit_req, src_bit, src_done,
        output src_bitreq, tx_bit, tx_datadone, busy, sel_err, overrun, bit_count
    );

    modport master (
        output tx_start, tx_abort, src_sel, bit_req, src_bit, src_done,
        input  src_bitreq, tx_bit, tx_datadone, busy, sel_err, overrun, bit_count
    );
endinterface

// File: rtl/txsrc_mux.sv
// Routes bit requests and data bits between the sequencer and one of NSRC sources,
// with a per-packet bit counter, MAXBITS overrun guard and select-range checking.
module txsrc_mux #(
    parameter int NSRC    = 4,
    parameter int SELW    = 2,
    parameter int MAXBITS = 512,
    parameter int CNTW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    txsrc_mux_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [SELW:0]   NSRC_W = (SELW+1)'(NSRC);
    localparam logic [CNTW-1:0] MAX_W  = CNTW'(MAXBITS);
    localparam logic [CNTW-1:0] ONE_W  = CNTW'(1);

    state_t          state_q;
    logic [SELW-1:0] sel_l_q;
    logic [CNTW-1:0] bit_count_q;
    logic            tx_bit_q;
    logic            tx_datadone_q;
    logic            busy_q;
    logic            sel_err_q;
    logic            overrun_q;

    logic            sel_ok_s;
    logic            cur_bit_s;
    logic            cur_done_s;
    logic            fwd_s;
    logic [NSRC-1:0] src_bitreq_s;

    // Select the latched source by compare-and-OR so unused codes never index the vectors
    always_comb begin
        cur_bit_s  = 1'b0;
        cur_done_s = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            cur_bit_s  = cur_bit_s  | (bus.src_bit[i]  & (sel_l_q == SELW'(i)));
            cur_done_s = cur_done_s | (bus.src_done[i] & (sel_l_q == SELW'(i)));
        end
    end

    // Forward decision and one-hot advance strobe, same cycle as bit_req
    always_comb begin
        sel_ok_s = ({1'b0, bus.src_sel} < NSRC_W);
        fwd_s    = (state_q == ST_ACTIVE) & bus.bit_req & ~cur_done_s &
                   (bit_count_q < MAX_W) & ~bus.tx_abort;
        src_bitreq_s = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            src_bitreq_s[i] = fwd_s & (sel_l_q == SELW'(i));
        end
    end

    // Packet FSM with all status outputs registered; abort overrides everything but reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sel_l_q       <= {SELW{1'b0}};
            bit_count_q   <= {CNTW{1'b0}};
            tx_bit_q      <= 1'b0;
            tx_datadone_q <= 1'b0;
            busy_q        <= 1'b0;
            sel_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else if (bus.tx_abort) begin
            state_q       <= ST_IDLE;
            bit_count_q   <= {CNTW{1'b0}};
            tx_datadone_q <= 1'b0;
            busy_q        <= 1'b0;
            sel_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.tx_start) begin
                        sel_l_q       <= bus.src_sel;
                        bit_count_q   <= {CNTW{1'b0}};
                        tx_bit_q      <= 1'b0;
                        overrun_q     <= 1'b0;
                        sel_err_q     <= ~sel_ok_s;
                        tx_datadone_q <= ~sel_ok_s;
                        busy_q        <= sel_ok_s;
                        state_q       <= sel_ok_s ? ST_ACTIVE : ST_DONE;
                    end
                end
                ST_ACTIVE: begin
                    if (cur_done_s) begin
                        state_q       <= ST_DONE;
                        tx_datadone_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else if (bus.bit_req && (bit_count_q == MAX_W)) begin
                        state_q       <= ST_DONE;
                        overrun_q     <= 1'b1;
                        tx_datadone_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else if (fwd_s) begin
                        // Sampled before the source advances on this same edge
                        tx_bit_q    <= cur_bit_s;
                        bit_count_q <= bit_count_q + ONE_W;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    tx_datadone_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.src_bitreq  = src_bitreq_s;
    assign bus.tx_bit      = tx_bit_q;
    assign bus.tx_datadone = tx_datadone_q;
    assign bus.busy        = busy_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.bit_count   = bit_count_q;

endmodule

// File: tb/tb_txsrc_mux.sv
// Directed bench for txsrc_mux: instance A (SELW=3, MAXBITS=512) and instance B
// (SELW=2, MAXBITS=8) share one stimulus; each scenario checks the relevant instance.
module tb_txsrc_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_start = 1'b0;
    logic        tx_abort = 1'b0;
    logic [2:0]  sel_r = 3'd0;
    logic        bit_req = 1'b0;
    logic [3:0]  src_bit_s;
    logic [3:0]  src_done_s;
    logic [15:0] pat = 16'hA5C3;
    int          idx;
    int          done_at = 1000;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        cur_b;

    always #5 clk = ~clk;

    txsrc_mux_if #(.NSRC(4), .SELW(3), .CNTW(10)) if_a ();
    txsrc_mux_if #(.NSRC(4), .SELW(2), .CNTW(4))  if_b ();

    txsrc_mux #(.NSRC(4), .SELW(3), .MAXBITS(512), .CNTW(10)) u_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    txsrc_mux #(.NSRC(4), .SELW(2), .MAXBITS(8), .CNTW(4)) u_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));

    assign if_a.tx_start = tx_start;
    assign if_a.tx_abort = tx_abort;
    assign if_a.src_sel  = sel_r;
    assign if_a.bit_req  = bit_req;
    assign if_a.src_bit  = src_bit_s;
    assign if_a.src_done = src_done_s;
    assign if_b.tx_start = tx_start;
    assign if_b.tx_abort = tx_abort;
    assign if_b.src_sel  = sel_r[1:0];
    assign if_b.bit_req  = bit_req;
    assign if_b.src_bit  = src_bit_s;
    assign if_b.src_done = src_done_s;

    // Source 1 streams pat MSB-first; the other sources carry inverted data and are always done
    always_comb begin
        cur_b      = (idx < 16) ? pat[15 - idx] : 1'b0;
        src_bit_s  = {~cur_b, ~cur_b, cur_b, ~cur_b};
        src_done_s = {1'b1, 1'b1, (idx >= done_at), 1'b1};
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)               idx <= 0;
        else if (tx_start)        idx <= 0;
        else if (if_a.src_bitreq[1]) idx <= idx + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic [2:0] sel, input int dat);
        done_at  = dat;
        sel_r    = sel;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic abort();
        tx_abort = 1'b1;
        tick();
        tx_abort = 1'b0;
    endtask

    task automatic send_bits(input int n);
        for (int k = 0; k < n; k++) begin
            bit_req = 1'b1;
            tick();
            bit_req = 1'b0;
            tick();
        end
    endtask

    initial begin
        // Reset state
        #2;
        check_val("rst_busy",   32'(if_a.busy),        32'd0);
        check_val("rst_done",   32'(if_a.tx_datadone), 32'd0);
        check_val("rst_cnt",    32'(if_a.bit_count),   32'd0);
        check_val("rst_selerr", 32'(if_a.sel_err),     32'd0);
        check_val("rst_ovr",    32'(if_a.overrun),     32'd0);
        check_val("rst_txbit",  32'(if_a.tx_bit),      32'd0);
        check_val("rst_req",    32'(if_a.src_bitreq),  32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Full 16-bit packet from source 1
        start(3'd1, 16);
        check_val("p1_busy", 32'(if_a.busy), 32'd1);
        for (int k = 0; k < 16; k++) begin
            bit_req = 1'b1;
            #1;
            check_val("p1_req", 32'(if_a.src_bitreq), 32'h2);
            tick();
            bit_req = 1'b0;
            check_val("p1_txbit", 32'(if_a.tx_bit), 32'(pat[15 - k]));
            tick();
        end
        check_val("p1_done", 32'(if_a.tx_datadone), 32'd1);
        check_val("p1_cnt",  32'(if_a.bit_count),   32'd16);
        check_val("p1_busy_end", 32'(if_a.busy),    32'd0);

        // Abort from DONE, then out-of-range select on instance A
        abort();
        check_val("ab_done", 32'(if_a.tx_datadone), 32'd0);
        check_val("ab_cnt",  32'(if_a.bit_count),   32'd0);
        start(3'd5, 1000);
        check_val("se_err",  32'(if_a.sel_err),     32'd1);
        check_val("se_done", 32'(if_a.tx_datadone), 32'd1);
        check_val("se_busy", 32'(if_a.busy),        32'd0);
        check_val("se_cnt",  32'(if_a.bit_count),   32'd0);
        for (int k = 0; k < 2; k++) begin
            bit_req = 1'b1;
            #1;
            check_val("se_req", 32'(if_a.src_bitreq), 32'd0);
            tick();
            bit_req = 1'b0;
            tick();
        end
        check_val("se_cnt2", 32'(if_a.bit_count), 32'd0);

        // MAXBITS=8 overrun on instance B
        abort();
        start(3'd1, 1000);
        for (int k = 0; k < 10; k++) begin
            bit_req = 1'b1;
            #1;
            check_val("ov_req", 32'(if_b.src_bitreq), (k < 8) ? 32'h2 : 32'h0);
            tick();
            bit_req = 1'b0;
            tick();
        end
        check_val("ov_cnt",  32'(if_b.bit_count),   32'd8);
        check_val("ov_flag", 32'(if_b.overrun),     32'd1);
        check_val("ov_done", 32'(if_b.tx_datadone), 32'd1);
        check_val("ov_busy", 32'(if_b.busy),        32'd0);

        // Abort mid-packet with a simultaneous bit_req
        abort();
        start(3'd1, 1000);
        send_bits(5);
        check_val("ma_cnt5", 32'(if_a.bit_count), 32'd5);
        bit_req  = 1'b1;
        tx_abort = 1'b1;
        #1;
        check_val("ma_req", 32'(if_a.src_bitreq), 32'd0);
        tick();
        bit_req  = 1'b0;
        tx_abort = 1'b0;
        check_val("ma_busy", 32'(if_a.busy),        32'd0);
        check_val("ma_cnt",  32'(if_a.bit_count),   32'd0);
        check_val("ma_done", 32'(if_a.tx_datadone), 32'd0);
        bit_req = 1'b1;
        #1;
        check_val("ma_idle_req", 32'(if_a.src_bitreq), 32'd0);
        tick();
        bit_req = 1'b0;
        tick();

        // bit_req in the same cycle src_done rises after 3 bits
        start(3'd1, 3);
        send_bits(2);
        bit_req = 1'b1;
        tick();
        #1;
        check_val("dw_req", 32'(if_a.src_bitreq), 32'd0);
        tick();
        bit_req = 1'b0;
        check_val("dw_cnt",   32'(if_a.bit_count),   32'd3);
        check_val("dw_done",  32'(if_a.tx_datadone), 32'd1);
        check_val("dw_busy",  32'(if_a.busy),        32'd0);
        check_val("dw_txbit", 32'(if_a.tx_bit),      32'd1);

        // Asynchronous reset while ACTIVE, then a clean packet
        abort();
        start(3'd1, 1000);
        send_bits(7);
        check_val("ar_cnt7", 32'(if_a.bit_count), 32'd7);
        #2;
        reset = 1'b0;
        #1;
        check_val("ar_busy", 32'(if_a.busy),        32'd0);
        check_val("ar_cnt",  32'(if_a.bit_count),   32'd0);
        check_val("ar_done", 32'(if_a.tx_datadone), 32'd0);
        check_val("ar_req",  32'(if_a.src_bitreq),  32'd0);
        tick();
        reset = 1'b1;
        tick();
        start(3'd1, 1000);
        check_val("cl_busy", 32'(if_a.busy),      32'd1);
        check_val("cl_cnt0", 32'(if_a.bit_count), 32'd0);
        send_bits(2);
        check_val("cl_txbit", 32'(if_a.tx_bit),    32'd0);
        check_val("cl_cnt2",  32'(if_a.bit_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
